gate_bist_ctrl: RTL and testbench
=================================

// Module: gate_bist_ctrl
// PURPOSE
//   Self-test driver/checker for the 8-bit lab gate datapath. Drives the gate's data input.
//   Generates pseudo-random stimulus from an LFSR and feeds it to the gate input.
//   Captures the gate output after a configurable latency and compresses it into an 8-bit
//   MISR signature. Sits beside the gate wrapper, sharing the wrapper's clock.
// PARAMETERS
//   LAT   3      DUT latency in cycles, legal 0..7 (output valid LAT cycles after input)
//   SEED  8'hA5  LFSR start value; 8'h00 is replaced by 8'h01
// PORTS
//   i_clk        in   1   clock, all state on rising edge
//   i_rst        in   1   asynchronous, active-high reset
//   i_start      in   1   start request, sampled only in IDLE
//   i_num_vec    in   8   vector count, sampled on accepted start; 0 means 256
//   o_dut_data   out  8   stimulus to gate input (registered)
//   i_dut_data   in   8   gate output to be captured
//   o_busy       out  1   high in DRIVE and DRAIN
//   o_done       out  1   one-cycle pulse in DONE
//   o_signature  out  8   MISR value, held from DONE until next accepted start
//   o_cap_count  out  9   number of captures in current/last run (max 256)
// BEHAVIOUR
//   Reset: state IDLE; o_dut_data, o_signature = 8'h00; o_cap_count = 0;
//     o_busy, o_done = 0; LFSR = SEED; valid pipe cleared.
//   Reset is asynchronous and takes effect immediately, including mid-run.
//   Nothing of the aborted run survives reset.
//   LFSR step: next = {l[6:0], l[7]^l[5]^l[4]^l[3]}.
//   MISR step: next = {m[6:0], m[7]^m[5]^m[4]^m[3]} ^ i_dut_data.
//   FSM states: IDLE -> DRIVE -> DRAIN -> DONE -> IDLE.
//   IDLE
//     o_dut_data = 0.
//     i_start=1 at edge k: load LFSR=SEED, remaining=N, MISR=0, o_cap_count=0; go DRIVE.
//   DRIVE
//     Cycles k+1 .. k+N.
//     Vector n (0-based) is on o_dut_data during cycle k+1+n.
//     Vector 0 = SEED; each later vector is the next LFSR step.
//     A valid bit enters an LAT-deep pipe with each vector.
//     After the N-th vector: o_dut_data returns to 0; go DRAIN.
//   Capture
//     At the end of cycle k+1+n+LAT, MISR absorbs i_dut_data and o_cap_count increments.
//     LAT=0 captures in the same cycle the vector is driven.
//   DRAIN
//     Lasts exactly LAT cycles (0 cycles if LAT=0).
//     Captures continue until the valid pipe is empty.
//   DONE
//     One cycle: o_done=1, o_busy=0, o_signature=MISR; then IDLE.
//   Busy/done timing
//     o_busy is high for exactly N+LAT cycles.
//     o_done follows immediately.
//     o_cap_count = N at o_done.
//   Boundary cases
//     i_start during DRIVE/DRAIN/DONE is ignored; no queueing.
//     i_start held high re-triggers only on the first edge after returning to IDLE.
//     i_num_vec changes while busy have no effect.
//     N=256: counter must not wrap early; o_cap_count reaches 9'd256.
//     o_signature is 0 while a run is in progress; the final value appears with o_done.
// TESTING
//   1. Reset assert/release, idle -> all outputs 0; assert i_rst mid-DRIVE -> same values at once.
//   2. LAT=0, identity loopback, N=1 -> o_dut_data=A5 for one cycle; o_signature=8'hA5, o_cap_count=1.
//   3. LAT=0, identity loopback, N=2 -> stimulus A5, 4A; o_signature=8'h00; o_busy exactly 2 cycles.
//   4. LAT=3, 3-register loopback, N=2 -> o_signature=8'h00; o_busy 5 cycles; o_done on 6th cycle.
//   5. N=0 (256), LAT=3 -> o_busy 259 cycles; o_cap_count=256; signature matches model.
//   6. i_start pulsed during DRIVE and DONE -> ignored, one o_done; restart clears signature to 0.

Source files
------------

// File: rtl/gate_bist_ctrl.sv
// BIST controller for the 8-bit gate: LFSR stimulus out, latency-aligned capture into an
// 8-bit MISR, signature published with a one-cycle done pulse.
module gate_bist_ctrl #(
  parameter int unsigned LAT  = 3,
  parameter logic [7:0]  SEED = 8'hA5
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic [7:0] i_num_vec,
  output logic [7:0] o_dut_data,
  input  logic [7:0] i_dut_data,
  output logic       o_busy,
  output logic       o_done,
  output logic [7:0] o_signature,
  output logic [8:0] o_cap_count
);

  localparam logic [7:0] SeedEff   = (SEED == 8'h00) ? 8'h01 : SEED;
  localparam logic [2:0] DrainInit = (LAT == 0) ? 3'd0 : 3'(LAT - 1);

  typedef enum logic [1:0] {StIdle, StDrive, StDrain, StDone} state_e;

  state_e     state_q, state_d;
  logic [7:0] lfsr_q, lfsr_d;
  logic [7:0] misr_q, misr_d;
  logic [7:0] sig_q, sig_d;
  logic [7:0] data_q, data_d;
  logic [8:0] remaining_q, remaining_d;
  logic [8:0] cap_q, cap_d;
  logic [2:0] drain_q, drain_d;
  logic       drive_vld;
  logic       cap_en;

  function automatic logic [7:0] fb_step(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  assign drive_vld = (state_q == StDrive);

  // Valid bit travels alongside each vector so capture lines up with the gate latency.
  if (LAT == 0) begin : g_nopipe
    assign cap_en = drive_vld;
  end else begin : g_pipe
    logic [LAT-1:0] vld_q;
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) vld_q <= '0;
      else       vld_q <= (vld_q << 1) | LAT'(drive_vld);
    end
    assign cap_en = vld_q[LAT-1];
  end

  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    misr_d      = misr_q;
    sig_d       = sig_q;
    data_d      = data_q;
    remaining_d = remaining_q;
    cap_d       = cap_q;
    drain_d     = drain_q;

    if (cap_en) begin
      misr_d = fb_step(misr_q) ^ i_dut_data;
      cap_d  = cap_q + 9'd1;
    end

    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          lfsr_d      = SeedEff;
          data_d      = SeedEff;
          remaining_d = (i_num_vec == 8'd0) ? 9'd256 : {1'b0, i_num_vec};
          misr_d      = 8'h00;
          cap_d       = 9'd0;
          sig_d       = 8'h00;
          state_d     = StDrive;
        end
      end
      StDrive: begin
        if (remaining_q == 9'd1) begin
          data_d      = 8'h00;
          remaining_d = 9'd0;
          if (LAT == 0) begin
            state_d = StDone;
          end else begin
            state_d = StDrain;
            drain_d = DrainInit;
          end
        end else begin
          remaining_d = remaining_q - 9'd1;
          lfsr_d      = fb_step(lfsr_q);
          data_d      = lfsr_d;
        end
      end
      StDrain: begin
        if (drain_q == 3'd0) state_d = StDone;
        else                 drain_d = drain_q - 3'd1;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // The last capture lands on the same edge that enters DONE, so publish misr_d.
    if (state_d == StDone && state_q != StDone) sig_d = misr_d;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= StIdle;
      lfsr_q      <= SeedEff;
      misr_q      <= 8'h00;
      sig_q       <= 8'h00;
      data_q      <= 8'h00;
      remaining_q <= 9'd0;
      cap_q       <= 9'd0;
      drain_q     <= 3'd0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      misr_q      <= misr_d;
      sig_q       <= sig_d;
      data_q      <= data_d;
      remaining_q <= remaining_d;
      cap_q       <= cap_d;
      drain_q     <= drain_d;
    end
  end

  assign o_dut_data  = data_q;
  assign o_busy      = (state_q == StDrive) || (state_q == StDrain);
  assign o_done      = (state_q == StDone);
  assign o_signature = sig_q;
  assign o_cap_count = cap_q;

endmodule

// File: tb/tb_gate_bist_ctrl.sv
// Bench for gate_bist_ctrl: LAT=0 and LAT=3 instances with keyed loopbacks, checked against a
// vector-list/signature model built from the LFSR and MISR rules.
module tb_gate_bist_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start0, start3;
  logic [7:0] nv0, nv3;
  logic [7:0] dout0, dout3, din0, din3;
  logic       busy0, busy3, done0, done3;
  logic [7:0] sig0, sig3;
  logic [8:0] cap0, cap3;
  logic [7:0] key0 = 8'h00, key3 = 8'h00;
  logic [7:0] r1, r2, r3;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_vec[$];
  logic [7:0] exp_sig;

  always #5 clk = ~clk;

  gate_bist_ctrl #(.LAT(0), .SEED(8'hA5)) u_lat0 (
    .i_clk(clk), .i_rst(rst), .i_start(start0), .i_num_vec(nv0), .o_dut_data(dout0),
    .i_dut_data(din0), .o_busy(busy0), .o_done(done0), .o_signature(sig0), .o_cap_count(cap0)
  );

  gate_bist_ctrl #(.LAT(3), .SEED(8'hA5)) u_lat3 (
    .i_clk(clk), .i_rst(rst), .i_start(start3), .i_num_vec(nv3), .o_dut_data(dout3),
    .i_dut_data(din3), .o_busy(busy3), .o_done(done3), .o_signature(sig3), .o_cap_count(cap3)
  );

  // Gate stand-ins: combinational for LAT=0, three registers for LAT=3.
  assign din0 = dout0 ^ key0;
  always_ff @(posedge clk) begin
    r1 <= dout3 ^ key3;
    r2 <= r1;
    r3 <= r2;
  end
  assign din3 = r3;

  function automatic logic [7:0] shift_fb(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  task automatic build_model(input int n, input logic [7:0] key);
    logic [7:0] v;
    logic [7:0] m;
    exp_vec.delete();
    v = 8'hA5;
    m = 8'h00;
    for (int i = 0; i < n; i++) begin
      exp_vec.push_back(v);
      m = shift_fb(m) ^ (v ^ key);
      v = shift_fb(v);
    end
    exp_sig = m;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_start(input bit use3, input logic s, input logic [7:0] nv);
    if (use3) begin start3 = s; nv3 = nv; end
    else      begin start0 = s; nv0 = nv; end
  endtask

  task automatic run(input bit use3, input int nv_in, input logic [7:0] key, input bit disturb);
    int n;
    int lat;
    int busy_cnt;
    logic b, d;
    logic [7:0] o, s;
    logic [8:0] c;
    n   = (nv_in == 0) ? 256 : nv_in;
    lat = use3 ? 3 : 0;
    build_model(n, key);
    if (use3) key3 = key; else key0 = key;
    @(negedge clk);
    set_start(use3, 1'b1, 8'(nv_in));
    @(negedge clk);
    set_start(use3, 1'b0, 8'($urandom));
    busy_cnt = 0;
    b = use3 ? busy3 : busy0;
    while (b && busy_cnt < 300) begin
      o = use3 ? dout3 : dout0;
      s = use3 ? sig3 : sig0;
      d = use3 ? done3 : done0;
      if (busy_cnt < n) check("stimulus", {8'h00, o}, {8'h00, exp_vec[busy_cnt]});
      else              check("stim_drain", {8'h00, o}, 16'h0000);
      check("sig_busy", {8'h00, s}, 16'h0000);
      check("done_busy", {15'd0, d}, 16'd0);
      if (disturb && busy_cnt == 1) set_start(use3, 1'b1, 8'($urandom));
      if (busy_cnt == 2) set_start(use3, 1'b0, 8'($urandom));
      busy_cnt++;
      @(negedge clk);
      b = use3 ? busy3 : busy0;
    end
    set_start(use3, 1'b0, 8'($urandom));
    check("busy_len", 16'(busy_cnt), 16'(n + lat));
    d = use3 ? done3 : done0;
    s = use3 ? sig3 : sig0;
    c = use3 ? cap3 : cap0;
    check("done", {15'd0, d}, 16'd1);
    check("signature", {8'h00, s}, {8'h00, exp_sig});
    check("cap_count", {7'd0, c}, 16'(n));
    if (disturb) set_start(use3, 1'b1, 8'($urandom));
    @(negedge clk);
    set_start(use3, 1'b0, 8'($urandom));
    b = use3 ? busy3 : busy0;
    d = use3 ? done3 : done0;
    s = use3 ? sig3 : sig0;
    check("idle_after", {14'd0, b, d}, 16'd0);
    check("sig_hold", {8'h00, s}, {8'h00, exp_sig});
  endtask

  initial begin
    rst = 1'b1; start0 = 1'b0; start3 = 1'b0; nv0 = 8'd0; nv3 = 8'd0;
    repeat (3) @(negedge clk);
    check("rst_lat0", {dout0, 8'(sig0 | 8'(cap0[8:1])), 6'd0, busy0, done0}, 16'h0000);
    check("rst_lat3", {dout3, 8'(sig3 | 8'(cap3[8:1])), 6'd0, busy3, done3}, 16'h0000);
    rst = 1'b0;
    @(negedge clk);
    check("idle_lat3", {dout3, sig3, 6'd0, busy3, done3}, 16'h0000);
    check("idle_cap", {7'd0, cap3}, 16'd0);

    run(1'b0, 1, 8'h00, 1'b0);
    check("n1_sig_const", {8'h00, sig0}, 16'h00A5);
    run(1'b0, 2, 8'h00, 1'b0);
    run(1'b1, 2, 8'h00, 1'b0);

    // Reset in the middle of a drive phase must clear everything immediately.
    @(negedge clk);
    set_start(1'b1, 1'b1, 8'd20);
    @(negedge clk);
    set_start(1'b1, 1'b0, 8'd0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_out", {dout3, sig3, 6'd0, busy3, done3}, 16'h0000);
    check("midrst_cap", {7'd0, cap3}, 16'd0);
    @(negedge clk);
    rst = 1'b0;

    run(1'b1, 0, 8'h00, 1'b0);
    run(1'b1, 5, 8'h3C, 1'b1);
    run(1'b0, 4, 8'(($urandom)), 1'b1);

    for (int i = 0; i < 8; i++) begin
      run(1'($urandom_range(0, 1)), int'($urandom_range(1, 40)), 8'($urandom),
          1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
